// File: rtl/board_pkg.sv
// Board-wide constants shared by the front-end blocks.
// Timing values for the 27 MHz board clock and the push-button settle time.
package board_pkg;

  localparam int CLK_HZ      = 27_000_000;
  localparam int DEBOUNCE_MS = 10;

endpackage

// File: rtl/debounce_bit.sv
// One button channel: two-flop synchroniser, stability counter, debounced level
// and registered press/release pulses.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // The counter tracks how long the synchronised level has disagreed with the
  // accepted level; any agreement clears it, so only an unbroken run flips state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta     <= 1'b0;
      sync          <= 1'b0;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_meta     <= ~btn_n;
      sync          <= sync_meta;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level         <= sync;
        cnt           <= '0;
        press_pulse   <= sync;
        release_pulse <= ~sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: WIDTH independent debounce channels turning raw
// active-low pins into clean active-high level, press and release signals.
module btn_debounce
  import board_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_state,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_n        (btn[i]),
      .level        (btn_state[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: constant vector table, hand-written
// corner sequences and random stimulus against a sliding-window reference model.
module tb_btn_debounce;

  localparam int WIDTH = 5;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] btn;
  logic [WIDTH-1:0] btn_state;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] hist[$];
  logic [WIDTH-1:0] exp_state;
  logic [WIDTH-1:0] exp_press;
  logic [WIDTH-1:0] exp_release;

  typedef struct {
    logic [WIDTH-1:0] btn;
    int               hold;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  btn_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // Synchronised level the design acts on at edge e (pins sampled two edges earlier).
  function automatic logic [WIDTH-1:0] syncAt(int e);
    if (e < 2) return '0;
    return ~hist[e-2];
  endfunction

  task automatic checkOutput(string name, logic [WIDTH-1:0] actual, logic [WIDTH-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
    end
  endtask

  task automatic checkInt(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic checkAll();
    checkOutput("model state", btn_state, exp_state);
    checkOutput("model press", btn_press, exp_press);
    checkOutput("model release", btn_release, exp_release);
    checkOutput("press/release exclusive", btn_press & btn_release, '0);
  endtask

  task automatic resetModel();
    hist.delete();
    exp_state   = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  // A channel flips once its last DC synchronised samples all oppose its level.
  task automatic modelEdge();
    int               e;
    logic             flip;
    logic [WIDTH-1:0] s;
    hist.push_back(btn);
    e           = hist.size() - 1;
    exp_press   = '0;
    exp_release = '0;
    for (int ch = 0; ch < WIDTH; ch++) begin
      flip = (e >= DC - 1);
      for (int j = 0; j < DC; j++) begin
        if (flip) begin
          s = syncAt(e - j);
          if (s[ch] == exp_state[ch]) flip = 1'b0;
        end
      end
      if (flip) begin
        exp_state[ch] = ~exp_state[ch];
        if (exp_state[ch]) exp_press[ch] = 1'b1;
        else               exp_release[ch] = 1'b1;
      end
    end
  endtask

  // Starts and ends at a falling edge; outputs checked 1 time unit after each rising edge.
  task automatic applyStimulus(logic [WIDTH-1:0] value, int cycles);
    for (int i = 0; i < cycles; i++) begin
      btn = value;
      @(posedge clk);
      if (rst_n) modelEdge();
      #1;
      checkAll();
      @(negedge clk);
    end
  endtask

  task automatic applyReset(logic [WIDTH-1:0] value, int cycles);
    btn   = value;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("reset immediate state", btn_state, '0);
    checkOutput("reset immediate press", btn_press, '0);
    checkOutput("reset immediate release", btn_release, '0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checkAll();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               n;
    logic [WIDTH-1:0] v;
    int               hold;

    vecs[0]  = '{5'h1F, 3,  5'h00, 5'h00, 5'h00};
    vecs[1]  = '{5'h1B, 5,  5'h00, 5'h00, 5'h00};
    vecs[2]  = '{5'h1B, 1,  5'h04, 5'h04, 5'h00};
    vecs[3]  = '{5'h1B, 1,  5'h04, 5'h00, 5'h00};
    vecs[4]  = '{5'h1F, 5,  5'h04, 5'h00, 5'h00};
    vecs[5]  = '{5'h1F, 1,  5'h00, 5'h00, 5'h04};
    vecs[6]  = '{5'h1E, 3,  5'h00, 5'h00, 5'h00};
    vecs[7]  = '{5'h1F, 10, 5'h00, 5'h00, 5'h00};
    vecs[8]  = '{5'h0E, 6,  5'h11, 5'h11, 5'h00};
    vecs[9]  = '{5'h0E, 2,  5'h11, 5'h00, 5'h00};
    vecs[10] = '{5'h1F, 6,  5'h00, 5'h00, 5'h11};

    rst_n = 1'b0;
    btn   = '1;
    resetModel();
    @(negedge clk);

    $display("[TB] reset with all buttons held");
    applyReset(5'h00, 3);
    applyStimulus(5'h00, 5);
    checkOutput("held at reset pre-accept", btn_state, 5'h00);
    applyStimulus(5'h00, 1);
    checkOutput("held at reset state", btn_state, 5'h1F);
    checkOutput("held at reset press", btn_press, 5'h1F);
    applyStimulus(5'h00, 1);
    checkOutput("held at reset press width", btn_press, 5'h00);

    $display("[TB] vector table");
    applyReset(5'h1F, 2);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].btn, vecs[k].hold);
      checkOutput($sformatf("vec%0d state", k), btn_state, vecs[k].state);
      checkOutput($sformatf("vec%0d press", k), btn_press, vecs[k].press);
      checkOutput($sformatf("vec%0d release", k), btn_release, vecs[k].rel);
    end

    $display("[TB] bounce on btn[3]");
    for (int p = 0; p < 5; p++) begin
      applyStimulus(5'h17, 2);
      checkOutput("bounce low phase", btn_state | btn_press, 5'h00);
      applyStimulus(5'h1F, 2);
      checkOutput("bounce high phase", btn_state | btn_press, 5'h00);
    end
    n = 0;
    for (int c = 1; c <= 20 && n == 0; c++) begin
      applyStimulus(5'h17, 1);
      if (btn_press[3]) n = c;
    end
    checkInt("bounce settle latency", n, 6);
    checkOutput("bounce settled state", btn_state, 5'h08);
    applyStimulus(5'h1F, 8);

    $display("[TB] simultaneous release of btn[1] and btn[4]");
    applyStimulus(5'h0D, 8);
    checkOutput("both held state", btn_state, 5'h12);
    applyStimulus(5'h1F, 5);
    checkOutput("release pending", btn_release, 5'h00);
    applyStimulus(5'h1F, 1);
    checkOutput("simultaneous release", btn_release, 5'h12);
    checkOutput("simultaneous release state", btn_state, 5'h00);

    $display("[TB] reset during a count");
    applyStimulus(5'h1E, 8);
    checkOutput("pre-reset state", btn_state, 5'h01);
    applyStimulus(5'h1A, 4);
    applyReset(5'h1A, 2);
    applyStimulus(5'h1A, 5);
    checkOutput("post-reset pending", btn_state, 5'h00);
    applyStimulus(5'h1A, 1);
    checkOutput("post-reset press", btn_press, 5'h05);
    checkOutput("post-reset state", btn_state, 5'h05);

    $display("[TB] random stimulus");
    v = 5'h1F;
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 24) == 0) begin
        applyReset(v, $urandom_range(1, 3));
      end
      v    = v ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      if ($urandom_range(0, 3) == 0) v = WIDTH'($urandom);
      hold = $urandom_range(1, 8);
      applyStimulus(v, hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
